// File: rtl/uart_wb_fifo.sv
// uart_wb_fifo: Wishbone 8N1 UART with TX/RX FIFOs,
// run-time baud divider, sticky errors and level irq.
module uart_wb_fifo #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 433
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        rx,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE, S_START, S_DATA, S_STOP
  } st_t;

  logic             req;
  logic             wr_q;
  logic             rd_pop_q;
  logic [1:0]       adr_q;
  logic             sel_q;
  logic [31:0]      wr_dat;
  logic             wr_acc;
  logic [31:0]      rd_val;
  logic [31:0]      status;
  logic [2:0]       w1c;

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_eff;
  logic [2:0]       irq_en;
  logic             rx_ovr;
  logic             frame_err;
  logic             tx_ovf;

  logic [7:0]       txq [FIFO_DEPTH];
  logic [AW-1:0]    tx_wp;
  logic [AW-1:0]    tx_rp;
  logic [LW-1:0]    tx_cnt;
  logic             tx_empty;
  logic             tx_full;
  logic             tx_push;
  logic             tx_wr;
  logic             tx_pop;
  logic             tx_ovf_set;

  logic [7:0]       rxq [FIFO_DEPTH];
  logic [AW-1:0]    rx_wp;
  logic [AW-1:0]    rx_rp;
  logic [LW-1:0]    rx_cnt;
  logic             rx_empty;
  logic             rx_full;
  logic             rx_push;
  logic             rx_wr;
  logic             rx_pop;
  logic             rx_ovr_set;
  logic             fe_set;

  st_t              tx_st;
  st_t              tx_nx;
  logic [DIV_W-1:0] tx_per;
  logic [DIV_W-1:0] tx_tmr;
  logic [2:0]       tx_bit;
  logic [7:0]       tx_sh;
  logic             tx_tick;
  logic             tx_busy;

  logic             rx_s1;
  logic             rx_s2;
  logic             rx_s3;
  logic             rx_fall;
  st_t              rx_st;
  st_t              rx_nx;
  logic [DIV_W-1:0] rx_per;
  logic [DIV_W-1:0] rx_tmr;
  logic [2:0]       rx_bit;
  logic [7:0]       rx_sh;
  logic             rx_half;
  logic             rx_tick;

  logic             unused;

  assign unused = ^{wb_adr_i[7:4], wb_adr_i[1:0],
                    wb_sel_i[3:1], wr_dat[31:8]};

  assign req    = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr_acc = wb_ack_o & wr_q & sel_q;
  assign rx_pop = wb_ack_o & rd_pop_q;

  assign w1c = (wr_acc && adr_q == 2'd1)
             ? wr_dat[6:4] : 3'b000;

  assign div_eff = (div < DIV_W'(2)) ? DIV_W'(2) : div;

  assign tx_empty   = (tx_cnt == '0);
  assign tx_full    = (tx_cnt == FULL);
  assign tx_push    = wr_acc & (adr_q == 2'd0);
  assign tx_wr      = tx_push & (~tx_full | tx_pop);
  assign tx_ovf_set = tx_push & tx_full & ~tx_pop;

  assign rx_empty   = (rx_cnt == '0);
  assign rx_full    = (rx_cnt == FULL);
  assign rx_wr      = rx_push & (~rx_full | rx_pop);
  assign rx_ovr_set = rx_push & rx_full & ~rx_pop;

  assign tx_busy = (tx_st != S_IDLE);
  assign tx_tick = (tx_tmr == tx_per);
  assign rx_fall = rx_s3 & ~rx_s2;
  assign rx_half = (rx_tmr == (rx_per >> 1));
  assign rx_tick = (rx_tmr == rx_per);

  assign status = {8'(tx_cnt), 8'(rx_cnt), 8'h00,
                   tx_busy, tx_ovf, frame_err, rx_ovr,
                   rx_full, rx_empty, tx_empty, tx_full};

  // read mux, sampled in the request cycle
  always_comb begin
    rd_val = '0;
    unique case (wb_adr_i[3:2])
      2'd0: rd_val = {24'h0,
                      rx_empty ? 8'h00 : rxq[rx_rp]};
      2'd1: rd_val = status;
      2'd2: rd_val = 32'(div);
      default: rd_val = {29'h0, irq_en};
    endcase
  end

  // bus handshake; side effects land in the ack cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack_o <= 1'b0;
      wr_q     <= 1'b0;
      rd_pop_q <= 1'b0;
      adr_q    <= 2'd0;
      sel_q    <= 1'b0;
      wr_dat   <= '0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      wr_q     <= req & wb_we_i;
      rd_pop_q <= req & ~wb_we_i & ~rx_empty
                & (wb_adr_i[3:2] == 2'd0);
      adr_q    <= wb_adr_i[3:2];
      sel_q    <= wb_sel_i[0];
      wr_dat   <= wb_dat_i;
      wb_dat_o <= (req & ~wb_we_i) ? rd_val : '0;
    end
  end

  // control registers, sticky flags (set beats clear), irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div       <= DIV_W'(DIV_RESET);
      irq_en    <= 3'b000;
      rx_ovr    <= 1'b0;
      frame_err <= 1'b0;
      tx_ovf    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (wr_acc && adr_q == 2'd2)
        div <= wr_dat[DIV_W-1:0];
      if (wr_acc && adr_q == 2'd3)
        irq_en <= wr_dat[2:0];
      rx_ovr    <= rx_ovr_set | (rx_ovr & ~w1c[0]);
      frame_err <= fe_set | (frame_err & ~w1c[1]);
      tx_ovf    <= tx_ovf_set | (tx_ovf & ~w1c[2]);
      irq <= |(irq_en & {rx_ovr | frame_err | tx_ovf,
                         tx_empty, ~rx_empty});
    end
  end

  // TX FIFO storage
  always_ff @(posedge clk) begin
    if (tx_wr)
      txq[tx_wp] <= wr_dat[7:0];
  end

  // TX FIFO pointers and level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_wr)
        tx_wp <= tx_wp + AW'(1);
      if (tx_pop)
        tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + LW'(tx_wr) - LW'(tx_pop);
    end
  end

  // RX FIFO storage
  always_ff @(posedge clk) begin
    if (rx_wr)
      rxq[rx_wp] <= rx_sh;
  end

  // RX FIFO pointers and level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr)
        rx_wp <= rx_wp + AW'(1);
      if (rx_pop)
        rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + LW'(rx_wr) - LW'(rx_pop);
    end
  end

  // TX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_st <= S_IDLE;
    else        tx_st <= tx_nx;
  end

  // TX next state; STOP chains straight into START
  always_comb begin
    tx_nx  = tx_st;
    tx_pop = 1'b0;
    unique case (tx_st)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_nx  = S_START;
        end
      end
      S_START: if (tx_tick) tx_nx = S_DATA;
      S_DATA: begin
        if (tx_tick && tx_bit == 3'd7)
          tx_nx = S_STOP;
      end
      default: begin
        if (tx_tick) begin
          tx_pop = ~tx_empty;
          tx_nx  = tx_empty ? S_IDLE : S_START;
        end
      end
    endcase
  end

  // TX bit timer, shifter and registered line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_per <= '0;
      tx_tmr <= '0;
      tx_bit <= 3'd0;
      tx_sh  <= 8'h00;
      tx     <= 1'b1;
    end else if (tx_pop) begin
      tx_sh  <= txq[tx_rp];
      tx_per <= div_eff;
      tx_tmr <= '0;
      tx_bit <= 3'd0;
      tx     <= 1'b0;
    end else if (tx_st != S_IDLE) begin
      if (!tx_tick) begin
        tx_tmr <= tx_tmr + DIV_W'(1);
      end else begin
        tx_tmr <= '0;
        if (tx_st == S_START)
          tx <= tx_sh[0];
        if (tx_st == S_DATA) begin
          tx_sh  <= tx_sh >> 1;
          tx_bit <= tx_bit + 3'd1;
          tx     <= (tx_bit == 3'd7) ? 1'b1 : tx_sh[1];
        end
        if (tx_st == S_STOP)
          tx <= 1'b1;
      end
    end
  end

  // RX synchroniser plus edge-detect tap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  // RX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_st <= S_IDLE;
    else        rx_st <= rx_nx;
  end

  // RX next state, push and framing decision
  always_comb begin
    rx_nx   = rx_st;
    rx_push = 1'b0;
    fe_set  = 1'b0;
    unique case (rx_st)
      S_IDLE: if (rx_fall) rx_nx = S_START;
      S_START: begin
        if (rx_half)
          rx_nx = rx_s2 ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (rx_tick && rx_bit == 3'd7)
          rx_nx = S_STOP;
      end
      default: begin
        if (rx_tick) begin
          rx_nx   = S_IDLE;
          rx_push = rx_s2;
          fe_set  = ~rx_s2;
        end
      end
    endcase
  end

  // RX bit timer and shifter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_per <= '0;
      rx_tmr <= '0;
      rx_bit <= 3'd0;
      rx_sh  <= 8'h00;
    end else if (rx_st == S_IDLE) begin
      rx_tmr <= '0;
      rx_bit <= 3'd0;
      if (rx_fall)
        rx_per <= div_eff;
    end else if (rx_st == S_START) begin
      rx_tmr <= rx_half ? '0 : rx_tmr + DIV_W'(1);
    end else if (rx_tick) begin
      rx_tmr <= '0;
      if (rx_st == S_DATA) begin
        rx_sh  <= {rx_s2, rx_sh[7:1]};
        rx_bit <= rx_bit + 3'd1;
      end
    end else begin
      rx_tmr <= rx_tmr + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_uart_wb_fifo.sv
// tb_uart_wb_fifo: scoreboard bench for uart_wb_fifo
// covering bus, loopback, FIFOs, errors and irq.
`timescale 1ns/1ps
module tb_uart_wb_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  adr = 8'h00;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] rdat;
  logic        ack;
  logic        tx;
  logic        irq;
  logic        rx_w;
  logic        rx_bit = 1'b1;
  logic        loop = 1'b0;
  logic        mon_en = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int bitp = 434;
  int last_ack = 0;

  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int         t_start[$];

  assign rx_w = loop ? tx : rx_bit;

  uart_wb_fifo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_dat_o (rdat),
    .wb_ack_o (ack),
    .rx       (rx_w),
    .tx       (tx),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic wb_xfer(input logic w,
                         input logic [7:0] a,
                         input logic [31:0] v,
                         input logic [3:0] s,
                         output logic [31:0] q,
                         output int t);
    logic got = 1'b0;
    cyc = 1'b1; stb = 1'b1; we = w;
    adr = a; wdat = v; sel = s;
    q = '0; t = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ack) begin
        q = rdat; t = cyc_n; got = 1'b1;
        break;
      end
    end
    if (!got) chk("wb_ack", 32'(got), 1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] a,
                       input logic [31:0] v);
    logic [31:0] q;
    int t;
    wb_xfer(1'b1, a, v, 4'hF, q, t);
    last_ack = t;
  endtask

  task automatic wb_rd(input logic [7:0] a,
                       output logic [31:0] q);
    int t;
    wb_xfer(1'b0, a, '0, 4'hF, q, t);
  endtask

  task automatic rd_data();
    logic [31:0] q;
    wb_rd(8'h00, q);
    if (exp_rx.size() == 0) chk("rx_extra", q, 0);
    else chk("rx_byte", q, {24'h0, exp_rx.pop_front()});
  endtask

  task automatic send(input logic [7:0] b,
                      input logic stop);
    rx_bit = 1'b0;
    repeat (bitp) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_bit = b[i];
      repeat (bitp) @(negedge clk);
    end
    rx_bit = stop;
    repeat (bitp) @(negedge clk);
    rx_bit = 1'b1;
  endtask

  task automatic wait_drain(input int lim);
    int k = 0;
    while (exp_tx.size() != 0 && k < lim) begin
      @(negedge clk);
      k++;
    end
    if (exp_tx.size() != 0)
      chk("tx_drain", 32'(exp_tx.size()), 0);
    repeat (20) @(negedge clk);
  endtask

  // serial TX monitor: decodes frames, pops the scoreboard
  initial begin : tx_mon
    logic [7:0] b;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (mon_en && !tx) begin
        t_start.push_back(cyc_n);
        repeat (bitp / 2) @(negedge clk);
        chk("tx_start", 32'(tx), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (bitp) @(negedge clk);
          b[i] = tx;
        end
        repeat (bitp) @(negedge clk);
        chk("tx_stop", 32'(tx), 1);
        if (exp_tx.size() == 0)
          chk("tx_extra", 32'(exp_tx.size()), 1);
        else
          chk("tx_byte", 32'(b), 32'(exp_tx.pop_front()));
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] d;
    int t;
    int n;

    repeat (3) @(negedge clk);
    chk("por_tx", 32'(tx), 1);
    chk("por_ack", 32'(ack), 0);
    chk("por_irq", 32'(irq), 0);
    chk("por_dat", rdat, 0);
    rst_n = 1'b1;
    @(negedge clk);

    wb_wr(8'h00, 32'h5A);
    repeat (20) @(negedge clk);
    chk("mid_frame_tx", 32'(tx), 0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_tx", 32'(tx), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wb_rd(8'h04, d); chk("rst_status", d, 32'h6);
    wb_rd(8'h08, d); chk("rst_div", d, 433);
    wb_rd(8'h0C, d); chk("rst_irqen", d, 0);

    wb_xfer(1'b1, 8'h08, 32'h9, 4'hE, d, t);
    wb_rd(8'h08, d); chk("div_sel0_off", d, 433);
    wb_wr(8'h08, 32'd9);
    bitp = 10;
    wb_rd(8'h08, d); chk("div_rd", d, 9);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    adr = 8'h04; sel = 4'hF; n = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack) n++;
    end
    cyc = 1'b0; stb = 1'b0;
    chk("held_stb_acks", n, 2);
    repeat (2) @(negedge clk);

    mon_en = 1'b1;
    loop = 1'b1;
    t_start.delete();
    exp_tx.push_back(8'hA5); exp_rx.push_back(8'hA5);
    wb_wr(8'h00, 32'hA5);
    t = last_ack;
    exp_tx.push_back(8'h3C); exp_rx.push_back(8'h3C);
    wb_wr(8'h00, 32'h3C);
    wait_drain(400);
    if (t_start.size() >= 2) begin
      chk("tx_latency", t_start[0] - t, 2);
      chk("b2b_gap", t_start[1] - t_start[0], 100);
    end else begin
      chk("lb_frames", t_start.size(), 2);
    end
    wb_rd(8'h04, d); chk("lb_rx_level", d[23:16], 2);
    rd_data();
    rd_data();
    loop = 1'b0;

    for (int i = 0; i < 18; i++) begin
      if (i < 17) exp_tx.push_back(8'(i));
      wb_wr(8'h00, 32'(i));
    end
    wb_rd(8'h04, d);
    chk("tx_ovf", d[6], 1);
    chk("tx_full", d[0], 1);
    chk("tx_level", d[31:24], 16);
    wb_wr(8'h04, 32'h40);
    wb_rd(8'h04, d); chk("tx_ovf_clr", d[6], 0);
    wait_drain(2500);

    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_rx.push_back(8'h80 + 8'(i));
      send(8'h80 + 8'(i), 1'b1);
    end
    repeat (5) @(negedge clk);
    wb_rd(8'h04, d);
    chk("rx_full", d[3], 1);
    chk("rx_ovr", d[4], 1);
    chk("rx_level16", d[23:16], 16);
    send(8'h77, 1'b0);
    repeat (2 * bitp) @(negedge clk);
    wb_rd(8'h04, d);
    chk("frame_err", d[5], 1);
    chk("fe_level", d[23:16], 16);
    repeat (16) rd_data();
    wb_rd(8'h00, d); chk("rd_empty", d, 0);
    wb_wr(8'h04, 32'h70);
    wb_rd(8'h04, d); chk("w1c_all", d, 32'h6);

    rx_bit = 1'b0;
    repeat (3) @(negedge clk);
    rx_bit = 1'b1;
    repeat (3 * bitp) @(negedge clk);
    wb_rd(8'h04, d); chk("glitch", d, 32'h6);

    wb_wr(8'h0C, 32'h1);
    repeat (3) @(negedge clk);
    chk("irq_idle", 32'(irq), 0);
    exp_rx.push_back(8'h55);
    send(8'h55, 1'b1);
    repeat (5) @(negedge clk);
    chk("irq_rx", 32'(irq), 1);
    rd_data();
    repeat (2) @(negedge clk);
    chk("irq_rx_clr", 32'(irq), 0);
    wb_wr(8'h0C, 32'h2);
    repeat (2) @(negedge clk);
    chk("irq_txe", 32'(irq), 1);
    wb_wr(8'h0C, 32'h4);
    repeat (2) @(negedge clk);
    chk("irq_err_off", 32'(irq), 0);
    send(8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("irq_err", 32'(irq), 1);
    wb_wr(8'h04, 32'h20);
    repeat (2) @(negedge clk);
    chk("irq_err_clr", 32'(irq), 0);
    wb_wr(8'h0C, 32'h0);

    for (int i = 0; i < 16; i++) begin
      exp_rx.push_back(8'h10 + 8'(i));
      send(8'h10 + 8'(i), 1'b1);
    end
    repeat (5) @(negedge clk);
    exp_rx.push_back(8'hC7);
    fork
      send(8'hC7, 1'b1);
      begin
        repeat (96) @(negedge clk);
        rd_data();
      end
    join
    repeat (5) @(negedge clk);
    wb_rd(8'h04, d);
    chk("pp_level", d[23:16], 16);
    chk("pp_ovr", d[4], 0);
    repeat (16) rd_data();
    chk("rx_sb_empty", exp_rx.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
